// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle for the branch predictor: lookup request,
// registered prediction, resolved-branch update and table flush.
interface branch_predictor_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  upd_branch_flag;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_branch_addr;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  flush;

    // Pipeline side: issues lookups, updates and flushes.
    modport master (
        output lookup_valid, lookup_pc,
        output upd_branch_flag, upd_taken, upd_branch_addr, upd_pc, flush,
        input  pred_valid, pred_taken, pred_target, pred_pc
    );

    // Predictor side.
    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_branch_flag, upd_taken, upd_branch_addr, upd_pc, flush,
        output pred_valid, pred_taken, pred_target, pred_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Flop-based table; predictions are registered one cycle after the lookup.
module branch_predictor #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ENTRIES    = 64
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Table storage
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q [ENTRIES];
    logic [ADDR_WIDTH-1:0] tgt_q [ENTRIES];
    logic [1:0]            ctr_q [ENTRIES];

    // Registered prediction
    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [ADDR_WIDTH-1:0] pred_target_q;
    logic [ADDR_WIDTH-1:0] pred_pc_q;

    // Lookup decode
    logic [IDX_W-1:0]      lu_idx_c;
    logic [TAG_W-1:0]      lu_tag_c;
    logic                  lu_hit_c;
    logic                  lu_taken_c;
    logic [ADDR_WIDTH-1:0] lu_target_c;

    // Update decode
    logic [IDX_W-1:0]      upd_idx_c;
    logic [TAG_W-1:0]      upd_tag_c;
    logic                  upd_hit_c;
    logic                  upd_ctr_we_c;
    logic                  upd_tgt_we_c;
    logic                  upd_alloc_c;
    logic [1:0]            upd_ctr_c;

    logic                  unused_pc_lsbs;

    // PC bits [1:0] carry no information for word-aligned instructions.
    assign unused_pc_lsbs = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    assign lu_idx_c  = bp.lookup_pc[IDX_W+1:2];
    assign lu_tag_c  = bp.lookup_pc[ADDR_WIDTH-1:IDX_W+2];
    assign upd_idx_c = bp.upd_pc[IDX_W+1:2];
    assign upd_tag_c = bp.upd_pc[ADDR_WIDTH-1:IDX_W+2];

    // Lookup reads pre-update table state; no update bypass.
    always_comb begin
        lu_hit_c    = 1'b0;
        lu_taken_c  = 1'b0;
        lu_target_c = '0;
        if (valid_q[lu_idx_c] && (tag_q[lu_idx_c] == lu_tag_c)) begin
            lu_hit_c = 1'b1;
        end
        if (lu_hit_c && ctr_q[lu_idx_c][1]) begin
            lu_taken_c  = 1'b1;
            lu_target_c = tgt_q[lu_idx_c];
        end
    end

    // Update decision: train on hit, allocate on taken miss.
    always_comb begin
        upd_hit_c    = 1'b0;
        upd_ctr_we_c = 1'b0;
        upd_tgt_we_c = 1'b0;
        upd_alloc_c  = 1'b0;
        upd_ctr_c    = ctr_q[upd_idx_c];
        if (valid_q[upd_idx_c] && (tag_q[upd_idx_c] == upd_tag_c)) begin
            upd_hit_c = 1'b1;
        end
        if (bp.upd_branch_flag) begin
            if (upd_hit_c) begin
                upd_ctr_we_c = 1'b1;
                if (bp.upd_taken) begin
                    upd_tgt_we_c = 1'b1;
                    if (ctr_q[upd_idx_c] != CTR_STRONG_T) begin
                        upd_ctr_c = ctr_q[upd_idx_c] + 2'd1;
                    end
                end else begin
                    if (ctr_q[upd_idx_c] != CTR_STRONG_NT) begin
                        upd_ctr_c = ctr_q[upd_idx_c] - 2'd1;
                    end
                end
            end else if (bp.upd_taken) begin
                upd_alloc_c = 1'b1;
                upd_ctr_c   = CTR_WEAK_T;
            end
        end
    end

    // Table state; flush only clears valid bits and wins over an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[IDX_W'(i)] <= '0;
                tgt_q[IDX_W'(i)] <= '0;
                ctr_q[IDX_W'(i)] <= CTR_WEAK_NT;
            end
        end else if (bp.flush) begin
            valid_q <= '0;
        end else if (upd_alloc_c) begin
            valid_q[upd_idx_c] <= 1'b1;
            tag_q[upd_idx_c]   <= upd_tag_c;
            tgt_q[upd_idx_c]   <= bp.upd_branch_addr;
            ctr_q[upd_idx_c]   <= upd_ctr_c;
        end else if (upd_ctr_we_c) begin
            ctr_q[upd_idx_c] <= upd_ctr_c;
            if (upd_tgt_we_c) begin
                tgt_q[upd_idx_c] <= bp.upd_branch_addr;
            end
        end
    end

    // Prediction register; pred_pc holds when no lookup is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_pc_q     <= '0;
        end else begin
            pred_valid_q <= bp.lookup_valid;
            if (bp.lookup_valid) begin
                pred_taken_q  <= lu_taken_c;
                pred_target_q <= lu_target_c;
                pred_pc_q     <= bp.lookup_pc;
            end else begin
                pred_taken_q  <= 1'b0;
                pred_target_q <= '0;
            end
        end
    end

    assign bp.pred_valid  = pred_valid_q;
    assign bp.pred_taken  = pred_taken_q;
    assign bp.pred_target = pred_target_q;
    assign bp.pred_pc     = pred_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level reference model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_branch_predictor;
    localparam int unsigned AW  = 32;
    localparam int unsigned ENT = 64;

    logic clk;
    logic rst_n;

    branch_predictor_if #(.ADDR_WIDTH(AW)) bp_if ();

    branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(ENT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    // Reference model: per-index entry as plain integers.
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    int unsigned m_tgt   [ENT];
    int          m_ctr   [ENT];
    bit          e_pv    = 1'b0;
    bit          e_taken = 1'b0;
    logic [31:0] e_tgt   = '0;
    logic [31:0] e_pc    = '0;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        e_pv = 1'b0; e_taken = 1'b0; e_tgt = '0; e_pc = '0;
    endfunction

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return int'(pc / (4 * ENT));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int i;
            bit hit;
            // prediction from the table as it stood before this edge
            if (bp_if.lookup_valid) begin
                i       = pc_idx(bp_if.lookup_pc);
                hit     = m_valid[i] && (m_tag[i] == pc_tag(bp_if.lookup_pc));
                e_pv    = 1'b1;
                e_taken = hit && (m_ctr[i] >= 2);
                e_tgt   = e_taken ? m_tgt[i] : 32'h0;
                e_pc    = bp_if.lookup_pc;
            end else begin
                e_pv = 1'b0; e_taken = 1'b0; e_tgt = '0;
            end
            if (bp_if.flush) begin
                for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
            end else if (bp_if.upd_branch_flag) begin
                i   = pc_idx(bp_if.upd_pc);
                hit = m_valid[i] && (m_tag[i] == pc_tag(bp_if.upd_pc));
                if (hit && bp_if.upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = bp_if.upd_branch_addr;
                end else if (hit) begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end else if (bp_if.upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = pc_tag(bp_if.upd_pc);
                    m_tgt[i]   = bp_if.upd_branch_addr;
                    m_ctr[i]   = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!done) begin
            check("model pred_valid", 32'(bp_if.pred_valid), 32'(e_pv));
            check("model pred_taken", 32'(bp_if.pred_taken), 32'(e_taken));
            check("model pred_target", bp_if.pred_target, e_tgt);
            check("model pred_pc", bp_if.pred_pc, e_pc);
        end
    end

    // One cycle of stimulus, applied at a falling edge.
    task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uf, input bit ut,
                       input logic [31:0] ua, input logic [31:0] upc, input bit fl);
        bp_if.lookup_valid    = lv;
        bp_if.lookup_pc       = lpc;
        bp_if.upd_branch_flag = uf;
        bp_if.upd_taken       = ut;
        bp_if.upd_branch_addr = ua;
        bp_if.upd_pc          = upc;
        bp_if.flush           = fl;
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input bit taken, input logic [31:0] addr);
        cyc(1'b0, 32'h0, 1'b1, taken, addr, pc, 1'b0);
    endtask

    task automatic expect_pred(input string name, input bit taken, input logic [31:0] tgt);
        check({name, " valid"}, 32'(bp_if.pred_valid), 32'd1);
        check({name, " taken"}, 32'(bp_if.pred_taken), 32'(taken));
        check({name, " target"}, bp_if.pred_target, tgt);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("reset pred_valid", 32'(bp_if.pred_valid), 32'd0);
        check("reset pred_pc", bp_if.pred_pc, 32'h0);
        rst_n = 1'b1;

        // cold lookup misses
        lookup(32'h1c000000);
        expect_pred("cold", 1'b0, 32'h0);
        check("cold pred_pc", bp_if.pred_pc, 32'h1c000000);

        // allocate on taken miss
        update(32'h1c000010, 1'b1, 32'h1c000100);
        check("idle pred_valid", 32'(bp_if.pred_valid), 32'd0);
        check("idle pred_pc hold", bp_if.pred_pc, 32'h1c000000);
        lookup(32'h1c000010);
        expect_pred("alloc", 1'b1, 32'h1c000100);

        // 10 -> 01 -> 00, then 01 -> 10
        update(32'h1c000010, 1'b0, 32'h0);
        update(32'h1c000010, 1'b0, 32'h0);
        lookup(32'h1c000010);
        expect_pred("strong nt", 1'b0, 32'h0);
        update(32'h1c000010, 1'b1, 32'h1c000100);
        update(32'h1c000010, 1'b1, 32'h1c000100);
        lookup(32'h1c000010);
        expect_pred("retrained", 1'b1, 32'h1c000100);

        // alias at index 4 replaces the entry
        update(32'h1c000110, 1'b1, 32'h1c000200);
        lookup(32'h1c000010);
        expect_pred("alias old", 1'b0, 32'h0);
        lookup(32'h1c000110);
        expect_pred("alias new", 1'b1, 32'h1c000200);

        // same-cycle lookup and update: no bypass
        cyc(1'b1, 32'h1c000020, 1'b1, 1'b1, 32'h1c000300, 32'h1c000020, 1'b0);
        expect_pred("no bypass", 1'b0, 32'h0);
        lookup(32'h1c000020);
        expect_pred("after update", 1'b1, 32'h1c000300);

        // saturation, then one not-taken leaves weak-taken
        for (int k = 0; k < 5; k++) update(32'h1c000020, 1'b1, 32'h1c000300);
        update(32'h1c000020, 1'b0, 32'h0);
        lookup(32'h1c000020);
        expect_pred("sat then nt", 1'b1, 32'h1c000300);

        // unqualified updates do nothing
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1c000020, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000400, 32'h1c000040, 1'b0);
        lookup(32'h1c000020);
        expect_pred("flag0 keep", 1'b1, 32'h1c000300);
        lookup(32'h1c000040);
        expect_pred("flag0 no alloc", 1'b0, 32'h0);

        // flush: same-cycle lookup sees old contents, later ones miss
        cyc(1'b1, 32'h1c000020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_pred("flush same cycle", 1'b1, 32'h1c000300);
        lookup(32'h1c000020);
        expect_pred("post flush a", 1'b0, 32'h0);
        lookup(32'h1c000110);
        expect_pred("post flush b", 1'b0, 32'h0);

        // flush beats a coincident allocate
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000500, 32'h1c000080, 1'b1);
        lookup(32'h1c000080);
        expect_pred("flush over update", 1'b0, 32'h0);

        // retrain, then reset asynchronously mid-stream
        update(32'h1c000020, 1'b1, 32'h1c000600);
        bp_if.lookup_valid    = 1'b1;
        bp_if.lookup_pc       = 32'h1c000020;
        bp_if.upd_branch_flag = 1'b0;
        @(posedge clk);
        #1;
        expect_pred("pre reset", 1'b1, 32'h1c000600);
        #2;
        rst_n = 1'b0;
        bp_if.lookup_valid = 1'b0;
        #1;
        check("async reset pred_valid", 32'(bp_if.pred_valid), 32'd0);
        check("async reset pred_taken", 32'(bp_if.pred_taken), 32'd0);
        check("async reset pred_target", bp_if.pred_target, 32'h0);
        check("async reset pred_pc", bp_if.pred_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h1c000020);
        expect_pred("after reset a", 1'b0, 32'h0);
        lookup(32'h1c000110);
        expect_pred("after reset b", 1'b0, 32'h0);
        lookup(32'h1c000010);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
